// File: rtl/aib_bridge_pkg.sv
// Shared types and widths for the AIB-to-AXI follower bridge link bring-up logic.
package aib_bridge_pkg;

    localparam int unsigned AVMM_ADDR_W = 17;
    localparam int unsigned AVMM_DATA_W = 32;
    localparam int unsigned AVMM_BE_W   = 4;

    // Bring-up sequencer states; the encoding is exported on seq_state for debug.
    typedef enum logic [3:0] {
        IDLE,
        CFG,
        RST,
        MACRDY,
        LOCK,
        ALIGN,
        ONLINE,
        FAIL
    } seq_state_t;

    typedef enum logic [1:0] {
        FC_NONE,
        FC_XFER_TIMEOUT,
        FC_ALIGN_TIMEOUT,
        FC_LINK_LOST
    } fail_code_t;

endpackage

// File: rtl/aib_link_bringup_seq_if.sv
// AVMM configuration write port between the bring-up sequencer and the AIB PHY.
interface aib_link_bringup_seq_if;
    import aib_bridge_pkg::*;

    logic [AVMM_ADDR_W-1:0] avmm_addr;
    logic [AVMM_DATA_W-1:0] avmm_wdata;
    logic [AVMM_BE_W-1:0]   avmm_byte_en;
    logic                   avmm_write;
    logic                   avmm_waitreq;

    modport master (
        output avmm_addr,
        output avmm_wdata,
        output avmm_byte_en,
        output avmm_write,
        input  avmm_waitreq
    );

    modport slave (
        input  avmm_addr,
        input  avmm_wdata,
        input  avmm_byte_en,
        input  avmm_write,
        output avmm_waitreq
    );

endinterface

// File: rtl/aib_link_bringup_seq.sv
// Link bring-up sequencer: replays the PHY config table over AVMM, walks the adapter through
// reset, MAC-ready and DCC/DLL lock, waits for transfer-enable and alignment, then brings the
// AXI side online and supervises it. All outputs are registered from the next-state decode.
module aib_link_bringup_seq
    import aib_bridge_pkg::*;
#(
    parameter int unsigned                          CFG_NUM     = 4,
    parameter logic [CFG_NUM*AVMM_ADDR_W-1:0]       CFG_ADDR    = '0,
    parameter logic [CFG_NUM*AVMM_DATA_W-1:0]       CFG_DATA    = '0,
    parameter int unsigned                          RST_HOLD    = 16,
    parameter int unsigned                          TIMEOUT_CYC = 65535
) (
    input  logic                   clk_wr,
    input  logic                   rst_wr,
    input  logic                   start,
    aib_link_bringup_seq_if.master avmm,
    output logic                   ns_adapter_rstn,
    output logic                   ns_mac_rdy,
    output logic                   sl_dcc_dll_lock_req,
    input  logic                   sl_tx_transfer_en,
    input  logic                   ms_tx_transfer_en,
    input  logic                   fs_mac_rdy,
    input  logic                   m_rx_align_done,
    output logic                   tx_online,
    output logic                   rx_online,
    output logic                   link_fail,
    output logic [1:0]             fail_code,
    output logic [3:0]             seq_state
);

    localparam int unsigned IDX_W = $clog2(CFG_NUM + 1);
    // Table padded to a power of two so idx indexes it at its natural width.
    localparam int unsigned TBL_N = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CFG_NUM - 1);
    localparam logic [15:0]      HOLD_LAST = 16'(RST_HOLD - 1);
    localparam logic [15:0]      TO_LAST   = 16'(TIMEOUT_CYC - 1);

    logic [AVMM_ADDR_W-1:0] cfg_addr_tbl [TBL_N];
    logic [AVMM_DATA_W-1:0] cfg_data_tbl [TBL_N];

    for (genvar i = 0; i < TBL_N; i++) begin : g_tbl
        if (i < CFG_NUM) begin : g_used
            assign cfg_addr_tbl[i] = CFG_ADDR[i*AVMM_ADDR_W +: AVMM_ADDR_W];
            assign cfg_data_tbl[i] = CFG_DATA[i*AVMM_DATA_W +: AVMM_DATA_W];
        end else begin : g_pad
            assign cfg_addr_tbl[i] = '0;
            assign cfg_data_tbl[i] = '0;
        end
    end

    seq_state_t             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [15:0]            cnt_q, cnt_d;
    fail_code_t             fail_code_q, fail_code_d;

    logic [AVMM_ADDR_W-1:0] addr_q, addr_d;
    logic [AVMM_DATA_W-1:0] wdata_q, wdata_d;
    logic [AVMM_BE_W-1:0]   byte_en_q, byte_en_d;
    logic                   write_q, write_d;
    logic                   rstn_q, rstn_d;
    logic                   mac_rdy_q, mac_rdy_d;
    logic                   lock_req_q, lock_req_d;
    logic                   online_q, online_d;
    logic                   link_fail_q, link_fail_d;

    logic                   xfer_ok;

    assign xfer_ok = sl_tx_transfer_en & ms_tx_transfer_en & fs_mac_rdy;

    // Next-state, config index, shared wait counter and failure code.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        fail_code_d = fail_code_q;

        unique case (state_q)
            IDLE, FAIL: begin
                if (start) begin
                    state_d     = CFG;
                    idx_d       = '0;
                    fail_code_d = FC_NONE;
                end
            end
            CFG: begin
                // avmm_write is always high in CFG, so no stall means the entry is taken.
                if (!avmm.avmm_waitreq) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = RST;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            RST: begin
                if (cnt_q >= HOLD_LAST) begin
                    state_d = MACRDY;
                end
            end
            MACRDY: begin
                state_d = LOCK;
            end
            LOCK: begin
                // Condition checked first so it wins over a coincident timeout.
                if (xfer_ok) begin
                    state_d = ALIGN;
                end else if (cnt_q >= TO_LAST) begin
                    state_d     = FAIL;
                    fail_code_d = FC_XFER_TIMEOUT;
                end
            end
            ALIGN: begin
                if (m_rx_align_done) begin
                    state_d = ONLINE;
                end else if (cnt_q >= TO_LAST) begin
                    state_d     = FAIL;
                    fail_code_d = FC_ALIGN_TIMEOUT;
                end
            end
            ONLINE: begin
                if (!(xfer_ok && m_rx_align_done)) begin
                    state_d     = FAIL;
                    fail_code_d = FC_LINK_LOST;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Cleared on every state entry, otherwise a saturating cycle count.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Output decode from the next state so outputs change on the transition edge.
    always_comb begin
        write_d     = (state_d == CFG);
        addr_d      = write_d ? cfg_addr_tbl[idx_d] : '0;
        wdata_d     = write_d ? cfg_data_tbl[idx_d] : '0;
        byte_en_d   = write_d ? 4'hF : 4'h0;
        rstn_d      = state_d inside {MACRDY, LOCK, ALIGN, ONLINE};
        mac_rdy_d   = state_d inside {MACRDY, LOCK, ALIGN, ONLINE};
        lock_req_d  = state_d inside {LOCK, ALIGN, ONLINE};
        online_d    = (state_d == ONLINE);
        link_fail_d = (state_d == FAIL);
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            fail_code_q <= FC_NONE;
            addr_q      <= '0;
            wdata_q     <= '0;
            byte_en_q   <= '0;
            write_q     <= 1'b0;
            rstn_q      <= 1'b0;
            mac_rdy_q   <= 1'b0;
            lock_req_q  <= 1'b0;
            online_q    <= 1'b0;
            link_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            fail_code_q <= fail_code_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            byte_en_q   <= byte_en_d;
            write_q     <= write_d;
            rstn_q      <= rstn_d;
            mac_rdy_q   <= mac_rdy_d;
            lock_req_q  <= lock_req_d;
            online_q    <= online_d;
            link_fail_q <= link_fail_d;
        end
    end

    assign avmm.avmm_addr      = addr_q;
    assign avmm.avmm_wdata     = wdata_q;
    assign avmm.avmm_byte_en   = byte_en_q;
    assign avmm.avmm_write     = write_q;
    assign ns_adapter_rstn     = rstn_q;
    assign ns_mac_rdy          = mac_rdy_q;
    assign sl_dcc_dll_lock_req = lock_req_q;
    assign tx_online           = online_q;
    assign rx_online           = online_q;
    assign link_fail           = link_fail_q;
    assign fail_code           = fail_code_q;
    assign seq_state           = state_q;

endmodule

// File: tb/tb_aib_link_bringup_seq.sv
// Bench for the link bring-up sequencer: a vector table for config/reset corners, then
// directed and randomized bring-up scenarios checked against a phase-timing model.
module tb_aib_link_bringup_seq;
    import aib_bridge_pkg::*;

    localparam int N    = 3;
    localparam int HOLD = 5;
    localparam int TO   = 100;

    localparam logic [16:0] A0 = 17'h00010;
    localparam logic [16:0] A1 = 17'h1ABCD;
    localparam logic [16:0] A2 = 17'h0F00F;
    localparam logic [31:0] D0 = 32'hDEADBEEF;
    localparam logic [31:0] D1 = 32'h12345678;
    localparam logic [31:0] D2 = 32'hA5A50F0F;

    logic       clk_wr = 1'b0;
    logic       rst_wr;
    logic       start;
    logic [3:0] st;
    logic       ns_adapter_rstn, ns_mac_rdy, sl_dcc_dll_lock_req;
    logic       tx_online, rx_online, link_fail;
    logic [1:0] fail_code;
    logic [3:0] seq_state;

    int checks   = 0;
    int failures = 0;

    logic [16:0] exp_addr [N];
    logic [31:0] exp_data [N];

    aib_link_bringup_seq_if avmm_if ();

    aib_link_bringup_seq #(
        .CFG_NUM     (N),
        .CFG_ADDR    ({A2, A1, A0}),
        .CFG_DATA    ({D2, D1, D0}),
        .RST_HOLD    (HOLD),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_wr              (clk_wr),
        .rst_wr              (rst_wr),
        .start               (start),
        .avmm                (avmm_if),
        .ns_adapter_rstn     (ns_adapter_rstn),
        .ns_mac_rdy          (ns_mac_rdy),
        .sl_dcc_dll_lock_req (sl_dcc_dll_lock_req),
        .sl_tx_transfer_en   (st[0]),
        .ms_tx_transfer_en   (st[1]),
        .fs_mac_rdy          (st[2]),
        .m_rx_align_done     (st[3]),
        .tx_online           (tx_online),
        .rx_online           (rx_online),
        .link_fail           (link_fail),
        .fail_code           (fail_code),
        .seq_state           (seq_state)
    );

    always #5 clk_wr = ~clk_wr;

    typedef struct {
        logic       rst;
        logic       start;
        logic       waitreq;
        seq_state_t exp_state;
        int         exp_idx;   // -1: no write expected
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic s, input logic w,
                                input seq_state_t es, input int ei);
        vec_t v;
        v.rst = r; v.start = s; v.waitreq = w; v.exp_state = es; v.exp_idx = ei;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_wr);
        #1;
    endtask

    function automatic logic [12:0] obs();
        return {seq_state, avmm_if.avmm_write, ns_adapter_rstn, ns_mac_rdy,
                sl_dcc_dll_lock_req, tx_online, rx_online, link_fail, fail_code};
    endfunction

    // Control outputs implied by a state: adapter up from MAC-ready on, lock request from
    // LOCK on, online only in ONLINE, failure flag and code only in FAIL.
    function automatic logic [12:0] expv(input seq_state_t s, input logic [1:0] code);
        logic up, lk;
        up = (s == MACRDY) || (s == LOCK) || (s == ALIGN) || (s == ONLINE);
        lk = (s == LOCK) || (s == ALIGN) || (s == ONLINE);
        return {4'(s), s == CFG, up, up, lk, s == ONLINE, s == ONLINE, s == FAIL, code};
    endfunction

    // One bring-up attempt from IDLE/FAIL. Phase boundaries (in edges after start) follow from
    // the stall counts and input delays; the run always ends in FAIL with the predicted code.
    task automatic run_scenario(input int s0, input int s1, input int s2, input int dx,
                                input int da, input int drop_sel, input int g,
                                input bit rand_start);
        bit         q[$];
        int         stalls[3];
        int         r, l, a, o, t_end, code, n_acc;
        stalls[0] = s0; stalls[1] = s1; stalls[2] = s2;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < stalls[k]; j++) q.push_back(1'b1);
            q.push_back(1'b0);
        end
        r = q.size();
        l = r + HOLD + 1;
        o = 0;
        if (dx < TO) begin
            a = l + dx + 1;
            if (da < TO) begin
                o = a + da + 1; t_end = o + g; code = 3;
            end else begin
                t_end = a + TO; code = 2;
            end
        end else begin
            a = -1; t_end = l + TO; code = 1;
        end
        n_acc = 0;
        start = 1'b1;
        for (int t = 0; t <= t_end; t++) begin
            seq_state_t es;
            logic [1:0] ec;
            logic       wr_next;
            int         e;
            step();
            if (t < r) es = CFG;
            else if (t < r + HOLD) es = RST;
            else if (t == r + HOLD) es = MACRDY;
            else if (t == t_end) es = FAIL;
            else if (a < 0 || t < a) es = LOCK;
            else if (code == 2 || t < o) es = ALIGN;
            else es = ONLINE;
            ec = (es == FAIL) ? 2'(code) : 2'd0;
            check("scn_ctrl", obs(), expv(es, ec));

            e = t + 1;
            wr_next = (q.size() > 0) ? q.pop_front() : 1'b0;
            if (avmm_if.avmm_write && !wr_next) begin
                if (n_acc < N) begin
                    check("scn_addr", avmm_if.avmm_addr, exp_addr[n_acc]);
                    check("scn_data", avmm_if.avmm_wdata, exp_data[n_acc]);
                    check("scn_be", avmm_if.avmm_byte_en, 4'hF);
                end
                n_acc++;
            end
            avmm_if.avmm_waitreq = wr_next;
            start = (rand_start && e <= t_end) ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (e > t_end) begin
                st = '0;
            end else begin
                st[2:0] = (dx < TO && e >= l + dx + 1) ? 3'b111 : 3'b000;
                st[3]   = (a >= 0 && da < TO && e >= a + da + 1);
                if (code == 3 && e == t_end) st[drop_sel] = 1'b0;
            end
        end
        check("scn_writes", n_acc, N);
        check("scn_end_fail", link_fail, 1'b1);
        check("scn_end_code", fail_code, code);
    endtask

    initial begin
        exp_addr[0] = A0; exp_addr[1] = A1; exp_addr[2] = A2;
        exp_data[0] = D0; exp_data[1] = D1; exp_data[2] = D2;
        rst_wr = 1'b1;
        start  = 1'b0;
        st     = '0;
        avmm_if.avmm_waitreq = 1'b0;
        step();
        step();
        check("reset_ctrl", obs(), expv(IDLE, 2'd0));
        check("reset_addr", avmm_if.avmm_addr, 17'h0);
        check("reset_data", avmm_if.avmm_wdata, 32'h0);
        check("reset_be", avmm_if.avmm_byte_en, 4'h0);

        // Back-to-back writes, a five-cycle stall on entry 1, and reset during a stall.
        vecs.push_back(mk(1, 0, 0, IDLE, -1));
        vecs.push_back(mk(0, 1, 0, CFG, 0));
        vecs.push_back(mk(0, 0, 0, CFG, 1));
        vecs.push_back(mk(0, 0, 0, CFG, 2));
        vecs.push_back(mk(0, 0, 0, RST, -1));
        vecs.push_back(mk(1, 0, 0, IDLE, -1));
        vecs.push_back(mk(0, 1, 0, CFG, 0));
        vecs.push_back(mk(0, 0, 0, CFG, 1));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 1, CFG, 1));
        vecs.push_back(mk(0, 0, 0, CFG, 2));
        vecs.push_back(mk(0, 0, 0, RST, -1));
        vecs.push_back(mk(1, 0, 0, IDLE, -1));
        vecs.push_back(mk(0, 1, 0, CFG, 0));
        vecs.push_back(mk(0, 0, 1, CFG, 0));
        vecs.push_back(mk(1, 0, 1, IDLE, -1));
        vecs.push_back(mk(0, 1, 0, CFG, 0));
        vecs.push_back(mk(0, 0, 0, CFG, 1));
        vecs.push_back(mk(0, 0, 0, CFG, 2));
        vecs.push_back(mk(0, 0, 0, RST, -1));

        foreach (vecs[i]) begin
            logic [16:0] ea;
            logic [31:0] ed;
            rst_wr = vecs[i].rst;
            start  = vecs[i].start;
            avmm_if.avmm_waitreq = vecs[i].waitreq;
            step();
            ea = (vecs[i].exp_idx >= 0) ? exp_addr[vecs[i].exp_idx] : 17'h0;
            ed = (vecs[i].exp_idx >= 0) ? exp_data[vecs[i].exp_idx] : 32'h0;
            check("vec_ctrl", obs(), expv(vecs[i].exp_state, 2'd0));
            check("vec_addr", avmm_if.avmm_addr, ea);
            check("vec_data", avmm_if.avmm_wdata, ed);
            check("vec_be", avmm_if.avmm_byte_en, (vecs[i].exp_idx >= 0) ? 4'hF : 4'h0);
        end

        rst_wr = 1'b1;
        start  = 1'b0;
        avmm_if.avmm_waitreq = 1'b0;
        step();
        rst_wr = 1'b0;

        // Status up 10 cycles after lock request, alignment 20 later, then fs_mac_rdy glitch.
        run_scenario(0, 0, 0, 9, 19, 2, 5, 1'b0);
        // Transfer-enable never arrives; restart from FAIL must replay the table.
        run_scenario(0, 0, 0, 1000, 0, 0, 1, 1'b0);
        // Condition arriving on the timeout cycle wins; one cycle later loses.
        run_scenario(1, 0, 2, TO - 1, TO - 1, 3, 2, 1'b0);
        run_scenario(0, 2, 0, 3, TO, 0, 1, 1'b0);

        for (int it = 0; it < 24; it++) begin
            int dx, da, sel;
            sel = $urandom_range(0, 9);
            dx  = (sel == 0) ? TO - 1 : (sel == 1) ? TO : (sel == 2) ? 300 : $urandom_range(0, 30);
            sel = $urandom_range(0, 9);
            da  = (sel == 0) ? TO - 1 : (sel == 1) ? TO : $urandom_range(0, 30);
            run_scenario($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                         dx, da, $urandom_range(0, 3), $urandom_range(1, 10), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
